// File: rtl/walnut_if.sv
// Walnut sprite control bus: planting/bite/shovel requests in, sprite state out.
interface walnut_if;
    logic       frame_tick;
    logic       place;
    logic [9:0] placeV;
    logic [9:0] placeH;
    logic       bite;
    logic       remove;
    logic [9:0] wVPosGiven;
    logic [9:0] wHPosGiven;
    logic       enable;
    logic       blink;
    logic [5:0] health;
    logic [1:0] damage;
    logic       occupied;
    logic       dead;

    // Game logic side drives the requests and observes the sprite state
    modport master (
        output frame_tick, place, placeV, placeH, bite, remove,
        input  wVPosGiven, wHPosGiven, enable, blink, health, damage, occupied, dead
    );

    // Walnut controller side
    modport slave (
        input  frame_tick, place, placeV, placeH, bite, remove,
        output wVPosGiven, wHPosGiven, enable, blink, health, damage, occupied, dead
    );
endinterface

// File: rtl/walnut_ctrl.sv
// Walnut plant controller: placement, health/damage tracking, idle blink animation.
// Optional hit flash enabled by defining WALNUT_HIT_FLASH_EN.
module walnut_ctrl #(
    parameter logic [5:0] HEALTH_MAX   = 6'd40,
    parameter logic [7:0] BLINK_PERIOD = 8'd120,
    parameter logic [7:0] BLINK_LEN    = 8'd8,
    parameter logic [3:0] FLASH_FRAMES = 4'd6
) (
    input  logic     clk,
    input  logic     rst_n,
    walnut_if.slave  bus
);

    localparam logic [7:0] BLINK_START = BLINK_PERIOD - BLINK_LEN;
    localparam logic [7:0] BLINK_LAST  = BLINK_PERIOD - 8'd1;

    typedef enum logic [0:0] {IDLE = 1'b0, ALIVE = 1'b1} state_e;

    state_e      state_q, state_d;
    logic [9:0]  vpos_q, vpos_d;
    logic [9:0]  hpos_q, hpos_d;
    logic [5:0]  health_q, health_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  damage_q, damage_d;
    logic        blink_q, blink_d;
    logic        dead_q, dead_d;
    logic        enable_q, enable_d;
    logic        alive_d;
    logic        hit_c;

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            vpos_q   <= 10'd0;
            hpos_q   <= 10'd0;
            health_q <= 6'd0;
            cnt_q    <= 8'd0;
            damage_q <= 2'd0;
            blink_q  <= 1'b0;
            dead_q   <= 1'b0;
            enable_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            vpos_q   <= vpos_d;
            hpos_q   <= hpos_d;
            health_q <= health_d;
            cnt_q    <= cnt_d;
            damage_q <= damage_d;
            blink_q  <= blink_d;
            dead_q   <= dead_d;
            enable_q <= enable_d;
        end
    end

    // Next-state: planting, bites, shovel and blink counter
    always_comb begin
        state_d  = state_q;
        vpos_d   = vpos_q;
        hpos_d   = hpos_q;
        health_d = health_q;
        cnt_d    = cnt_q;
        dead_d   = 1'b0;
        hit_c    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.place) begin
                    state_d  = ALIVE;
                    vpos_d   = bus.placeV;
                    hpos_d   = bus.placeH;
                    health_d = HEALTH_MAX;
                    cnt_d    = 8'd0;
                end
            end
            ALIVE: begin
                // Shovel wins over a simultaneous bite and never reports a death
                if (bus.remove) begin
                    state_d  = IDLE;
                    health_d = 6'd0;
                end else if (bus.bite) begin
                    if (health_q > 6'd1) begin
                        health_d = health_q - 6'd1;
                        hit_c    = 1'b1;
                    end else begin
                        health_d = 6'd0;
                        dead_d   = 1'b1;
                        state_d  = IDLE;
                    end
                end
                if (bus.frame_tick) begin
                    cnt_d = (cnt_q == BLINK_LAST) ? 8'd0 : cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        alive_d  = (state_d == ALIVE);
        blink_d  = alive_d && (cnt_d >= BLINK_START);
        if (!alive_d) begin
            damage_d = 2'd0;
        end else if (health_d > 6'd26) begin
            damage_d = 2'd0;
        end else if (health_d > 6'd13) begin
            damage_d = 2'd1;
        end else begin
            damage_d = 2'd2;
        end
    end

`ifdef WALNUT_HIT_FLASH_EN
    logic [3:0] flash_q, flash_d;
    logic       phase_q, phase_d;

    // Hit flash counter and visibility phase
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flash_q <= 4'd0;
            phase_q <= 1'b0;
        end else begin
            flash_q <= flash_d;
            phase_q <= phase_d;
        end
    end

    // A new hit restarts the flash; each frame tick consumes one flash frame
    always_comb begin
        flash_d = flash_q;
        phase_d = phase_q;
        if (state_q == IDLE && bus.place) begin
            flash_d = 4'd0;
            phase_d = 1'b0;
        end else if (hit_c) begin
            flash_d = FLASH_FRAMES;
            phase_d = 1'b0;
        end else if (bus.frame_tick && (flash_q != 4'd0)) begin
            flash_d = flash_q - 4'd1;
            phase_d = ~phase_q;
        end
        enable_d = alive_d && !phase_d;
    end
`else
    logic unused_flash;
    assign unused_flash = ^{FLASH_FRAMES, hit_c};

    // Sprite visible whenever a walnut is planted
    always_comb begin
        enable_d = alive_d;
    end
`endif

    assign bus.wVPosGiven = vpos_q;
    assign bus.wHPosGiven = hpos_q;
    assign bus.enable     = enable_q;
    assign bus.blink      = blink_q;
    assign bus.health     = health_q;
    assign bus.damage     = damage_q;
    assign bus.occupied   = (state_q == ALIVE);
    assign bus.dead       = dead_q;

endmodule
